dtim_lsu: RTL and testbench
===========================

// Module: dtim_lsu
// PURPOSE
//  Load/store unit between the BLI201 core execute stage and the DTIM data BRAM.
//  Converts byte/half/word requests into a word address, byte write mask and lane-replicated write data.
//  Aligns and sign/zero-extends load data returning one cycle after the read.
//  Rejects misaligned accesses. Buffers a stalled load response, since the BRAM output is not held.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width of the DTIM window; word index = addr[ADDR_WIDTH-1:2]
// PORTS
//  clk              in   1           clock
//  rst              in   1           synchronous active-high reset
//  lsu_i_valid      in   1           request valid
//  lsu_o_ready      out  1           request accepted when valid&ready
//  lsu_i_we         in   1           1=store, 0=load
//  lsu_i_size       in   2           00 byte, 01 half, 10 word, 11 illegal (treated misaligned)
//  lsu_i_unsigned   in   1           load zero-extend (LBU/LHU); ignored for stores/words
//  lsu_i_addr       in   ADDR_WIDTH  byte address
//  lsu_i_wdata      in   32          store data, right-justified
//  lsu_o_rvalid     out  1           response valid (load data or error)
//  lsu_i_rready     in   1           response consumed when rvalid&rready
//  lsu_o_rdata      out  32          extended load data; 0 on error
//  lsu_o_err        out  1           misaligned/illegal access, qualified by rvalid
//  dtim_o_addr      out  ADDR_WIDTH  byte address to DTIM (word index in [ADDR_WIDTH-1:2])
//  dtim_o_wmask     out  4           byte write enables
//  dtim_o_wdata     out  32          lane-replicated store data
//  dtim_i_rdata     in   32          DTIM read word, valid the cycle after address
// BEHAVIOUR
//  Reset: state IDLE, lsu_o_rvalid=0, lsu_o_err=0, lsu_o_rdata=0, hold reg=0.
//  Reset: lsu_o_ready=1 the cycle after reset deasserts. Reset mid-operation drops any pending response.
//  acc = lsu_i_valid & lsu_o_ready.
//  mis = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | size==11.
//  dtim_o_addr = lsu_i_addr, combinational every cycle.
//  dtim_o_wmask = 0 unless acc & we & !mis:
//    - byte: 4'b0001<<addr[1:0]
//    - half: 4'b0011<<addr[1:0]
//    - word: 4'b1111
//  dtim_o_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
//  Aligned stores: write occurs in the accept cycle; no response is generated.
//  Accepted misaligned access (load or store): no write.
//    - Next cycle: rvalid=1, err=1, rdata=0.
//  Aligned load: registers addr[1:0], size and unsigned at accept.
//    - Next cycle: rvalid=1, err=0.
//    - rdata = the selected byte/half of dtim_i_rdata, shifted by the offset, then sign/zero-extended.
//    - Word loads pass through unchanged.
//  FSM:
//    - IDLE: ready=1, rvalid=0.
//    - RESP: rvalid=1, rdata sourced live from the BRAM alignment path.
//    - HOLD: rvalid=1, rdata from the hold register; ready=0.
//  Transitions:
//    - IDLE, acc producing a response -> RESP.
//    - RESP & rready & acc producing a response -> RESP (back-to-back, 1 load/cycle).
//    - RESP & rready & no new response -> IDLE.
//    - RESP & !rready -> HOLD; the aligned data/err is captured into the hold register that cycle.
//    - HOLD & rready -> IDLE. New requests are never accepted in HOLD.
//  lsu_o_ready = (state==IDLE) | (state==RESP & lsu_i_rready).
//  Stores are accepted under the same rule as loads, so a store never overtakes an unconsumed response.
//  Simultaneous store accept + load response consume in RESP: the write occurs and the state goes to IDLE.
//  Response order equals request order. At most one response is outstanding.
//  Latency:
//    - load: 1 cycle accept->rvalid
//    - store: 0 (write in accept cycle)
//  Full throughput is one request per cycle while rready=1.
// TESTING
//  1) SW 0xDEADBEEF @0x010, then LW @0x010 -> wmask=1111 on store; rvalid next cycle, rdata=0xDEADBEEF, err=0.
//  2) Word @0x020=0x80F17F01; LB/LBU @0x021..0x023 -> 0x0000007F, 0xFFFFFFF1/0x000000F1, 0xFFFFFF80.
//  3) SH 0xA5A5 @0x042 -> wmask=1100, wdata=0xA5A5A5A5; LH @0x042 -> 0xFFFFA5A5; LHU -> 0x0000A5A5.
//  4) LW @0x013 and SH @0x001 -> no write (wmask=0); each gives rvalid=1, err=1, rdata=0.
//  5) LW @0x010 with rready=0 for 3 cycles while BRAM addr changes -> HOLD, ready=0, rdata stable; rready=1 -> IDLE.
//  6) Back-to-back LW x4 with rready=1 -> 4 consecutive rvalid cycles in order; rst mid-stream -> rvalid=0 next cycle.

Source files
------------

// File: rtl/dtim_lsu.sv
// Load/store unit between the core execute stage and the DTIM BRAM.
// Builds write masks/lane data, aligns and extends load data, and buffers stalled responses.
module dtim_lsu #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_i_valid,
  output logic                  lsu_o_ready,
  input  logic                  lsu_i_we,
  input  logic [1:0]            lsu_i_size,
  input  logic                  lsu_i_unsigned,
  input  logic [ADDR_WIDTH-1:0] lsu_i_addr,
  input  logic [31:0]           lsu_i_wdata,
  output logic                  lsu_o_rvalid,
  input  logic                  lsu_i_rready,
  output logic [31:0]           lsu_o_rdata,
  output logic                  lsu_o_err,
  output logic [ADDR_WIDTH-1:0] dtim_o_addr,
  output logic [3:0]            dtim_o_wmask,
  output logic [31:0]           dtim_o_wdata,
  input  logic [31:0]           dtim_i_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RESP = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t      state;
  logic [1:0]  rsp_off;
  logic [1:0]  rsp_size;
  logic        rsp_uns;
  logic        rsp_err;
  logic [31:0] hold_data;
  logic        hold_err;

  logic        mis;
  logic        acc;
  logic        resp_gen;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] aligned;
  logic [31:0] live_data;

  assign off = lsu_i_addr[1:0];

  always_comb begin
    mis = 1'b0;
    case (lsu_i_size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
  end

  // Ready is held low while reset is asserted so nothing is written during reset.
  assign lsu_o_ready = ~rst & ((state == IDLE) | ((state == RESP) & lsu_i_rready));
  assign acc         = lsu_i_valid & lsu_o_ready;
  assign resp_gen    = acc & (~lsu_i_we | mis);

  assign dtim_o_addr = lsu_i_addr;

  always_comb begin
    dtim_o_wmask = 4'b0000;
    if (acc && lsu_i_we && !mis) begin
      case (lsu_i_size)
        SZ_BYTE: dtim_o_wmask = 4'b0001 << off;
        SZ_HALF: dtim_o_wmask = 4'b0011 << off;
        default: dtim_o_wmask = 4'b1111;
      endcase
    end
  end

  always_comb begin
    dtim_o_wdata = lsu_i_wdata;
    case (lsu_i_size)
      SZ_BYTE: dtim_o_wdata = {4{lsu_i_wdata[7:0]}};
      SZ_HALF: dtim_o_wdata = {2{lsu_i_wdata[15:0]}};
      default: dtim_o_wdata = lsu_i_wdata;
    endcase
  end

  // Live alignment of the BRAM word using the offset/size captured at accept.
  always_comb begin
    shifted = dtim_i_rdata >> {rsp_off, 3'b000};
    aligned = dtim_i_rdata;
    case (rsp_size)
      SZ_BYTE: aligned = {{24{~rsp_uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: aligned = {{16{~rsp_uns & shifted[15]}}, shifted[15:0]};
      default: aligned = dtim_i_rdata;
    endcase
    live_data = rsp_err ? 32'h0000_0000 : aligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_off   <= 2'b00;
      rsp_size  <= 2'b00;
      rsp_uns   <= 1'b0;
      rsp_err   <= 1'b0;
      hold_data <= 32'h0000_0000;
      hold_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (resp_gen) state <= RESP;
        end
        RESP: begin
          if (lsu_i_rready) begin
            state <= resp_gen ? RESP : IDLE;
          end else begin
            state     <= HOLD;
            hold_data <= live_data;
            hold_err  <= rsp_err;
          end
        end
        HOLD: begin
          if (lsu_i_rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (resp_gen) begin
        rsp_off  <= off;
        rsp_size <= lsu_i_size;
        rsp_uns  <= lsu_i_unsigned;
        rsp_err  <= mis;
      end
    end
  end

  always_comb begin
    lsu_o_rvalid = 1'b0;
    lsu_o_err    = 1'b0;
    lsu_o_rdata  = 32'h0000_0000;
    case (state)
      RESP: begin
        lsu_o_rvalid = 1'b1;
        lsu_o_err    = rsp_err;
        lsu_o_rdata  = live_data;
      end
      HOLD: begin
        lsu_o_rvalid = 1'b1;
        lsu_o_err    = hold_err;
        lsu_o_rdata  = hold_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dtim_lsu.sv
// Scoreboard bench for dtim_lsu with a behavioural synchronous-read DTIM model.
module tb_dtim_lsu;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_i_valid;
  logic          lsu_o_ready;
  logic          lsu_i_we;
  logic [1:0]    lsu_i_size;
  logic          lsu_i_unsigned;
  logic [AW-1:0] lsu_i_addr;
  logic [31:0]   lsu_i_wdata;
  logic          lsu_o_rvalid;
  logic          lsu_i_rready;
  logic [31:0]   lsu_o_rdata;
  logic          lsu_o_err;
  logic [AW-1:0] dtim_o_addr;
  logic [3:0]    dtim_o_wmask;
  logic [31:0]   dtim_o_wdata;
  logic [31:0]   dtim_i_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [32:0] sb[$];
  int          resp_cyc[$];
  logic [31:0] mem[0:1023];

  dtim_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .lsu_i_valid(lsu_i_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_i_we(lsu_i_we), .lsu_i_size(lsu_i_size),
    .lsu_i_unsigned(lsu_i_unsigned), .lsu_i_addr(lsu_i_addr),
    .lsu_i_wdata(lsu_i_wdata), .lsu_o_rvalid(lsu_o_rvalid),
    .lsu_i_rready(lsu_i_rready), .lsu_o_rdata(lsu_o_rdata),
    .lsu_o_err(lsu_o_err), .dtim_o_addr(dtim_o_addr),
    .dtim_o_wmask(dtim_o_wmask), .dtim_o_wdata(dtim_o_wdata),
    .dtim_i_rdata(dtim_i_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous BRAM model
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dtim_o_wmask[b]) mem[dtim_o_addr[AW-1:2]][b*8 +: 8] <= dtim_o_wdata[b*8 +: 8];
    dtim_i_rdata <= mem[dtim_o_addr[AW-1:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && lsu_o_rvalid && lsu_i_rready) begin
      resp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("rsp_err", 32'(lsu_o_err), 32'(e[32]));
        check("rsp_rdata", lsu_o_rdata, e[31:0]);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    int n;
    lsu_i_valid = 1'b1; lsu_i_we = we; lsu_i_size = size;
    lsu_i_unsigned = uns; lsu_i_addr = addr; lsu_i_wdata = wd;
    @(negedge clk);
    n = 0;
    while (!lsu_o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_o_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      check("wmask", 32'(dtim_o_wmask), 32'(exp_mask));
      if (we && !exp_err) check("wdata", dtim_o_wdata, exp_wd);
      if (!we || exp_err) sb.push_back({exp_err, exp_rd});
    end
    @(posedge clk);
    #1;
    lsu_i_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; lsu_i_valid = 1'b0; lsu_i_we = 1'b0; lsu_i_size = 2'b00;
    lsu_i_unsigned = 1'b0; lsu_i_addr = '0; lsu_i_wdata = '0; lsu_i_rready = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    check("rst_rvalid", 32'(lsu_o_rvalid), 32'd0);
    check("rst_err", 32'(lsu_o_err), 32'd0);
    check("rst_rdata", lsu_o_rdata, 32'd0);
    check("rst_ready", 32'(lsu_o_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(lsu_o_ready), 32'd1);
    @(posedge clk); #1;

    // 1) word store then load
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);
    idle_cycles(1);

    // 2) byte loads with sign/zero extension
    issue(1'b1, 2'b10, 1'b0, 12'h020, 32'h80F17F01, 1'b0, 32'h0, 4'b1111, 32'h80F17F01);
    issue(1'b0, 2'b00, 1'b0, 12'h021, 32'h0, 1'b0, 32'h0000007F, 4'b0000, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 12'h022, 32'h0, 1'b0, 32'hFFFFFFF1, 4'b0000, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'h022, 32'h0, 1'b0, 32'h000000F1, 4'b0000, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 12'h023, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'h020, 32'h0, 1'b0, 32'h00000001, 4'b0000, 32'h0);
    idle_cycles(1);

    // 3) upper-half store, signed and unsigned half loads, byte store lane
    issue(1'b1, 2'b01, 1'b0, 12'h042, 32'h0000A5A5, 1'b0, 32'h0, 4'b1100, 32'hA5A5A5A5);
    issue(1'b0, 2'b01, 1'b0, 12'h042, 32'h0, 1'b0, 32'hFFFFA5A5, 4'b0000, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 12'h042, 32'h0, 1'b0, 32'h0000A5A5, 4'b0000, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 12'h041, 32'h00000033, 1'b0, 32'h0, 4'b0010, 32'h33333333);
    issue(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 1'b0, 32'hA5A53300, 4'b0000, 32'h0);
    idle_cycles(1);

    // 4) misaligned / illegal accesses
    issue(1'b0, 2'b10, 1'b0, 12'h013, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 12'h001, 32'h1234, 1'b1, 32'h0, 4'b0000, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 12'h000, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0);
    idle_cycles(1);
    issue(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
    idle_cycles(1);

    // 5) stalled response held while BRAM address wanders
    lsu_i_rready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      lsu_i_addr = 12'(12'h020 + 12'(i * 4));
      lsu_i_valid = 1'b1;
      @(negedge clk);
      check("hold_rvalid", 32'(lsu_o_rvalid), 32'd1);
      check("hold_ready", 32'(lsu_o_ready), 32'd0);
      check("hold_rdata", lsu_o_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    lsu_i_valid = 1'b0;
    lsu_i_rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_hold_rvalid", 32'(lsu_o_rvalid), 32'd0);
    check("post_hold_ready", 32'(lsu_o_ready), 32'd1);
    @(posedge clk); #1;

    // 6) back-to-back loads, then reset with a response pending
    base = resp_cyc.size();
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 1'b0, 32'h80F17F01, 4'b0000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 1'b0, 32'hA5A53300, 4'b0000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 1'b0, 32'h00000000, 4'b0000, 32'h0);
    idle_cycles(2);
    check("b2b_count", 32'(resp_cyc.size() - base), 32'd4);
    if (resp_cyc.size() >= base + 4)
      check("b2b_spacing", 32'(resp_cyc[base+3] - resp_cyc[base]), 32'd3);

    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 1'b0, 32'h80F17F01, 4'b0000, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check("rst_mid_rvalid", 32'(lsu_o_rvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(lsu_o_ready), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
